// File: rtl/mc_alu.sv
`default_nettype none
// ============================================================================
// Module   : mc_alu
// Brief    : Multi-cycle execute-stage ALU. Logic/compare ops complete with
//            latency 1; multiply/divide iterate one bit per cycle into HI/LO.
// Config   : define MC_ALU_DIV_EN to include the divider datapath and DIV
//            state; otherwise DIV/DIVU decode as illegal and div0 is 0.
// Revision : 1.0 - initial release
// ============================================================================
module mc_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [3:0]       ALU_control,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             isZero,
    output logic             div0,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLTU  = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_NOR   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_MULT  = 4'b1001;
    localparam logic [3:0] OP_MFHI  = 4'b1100;
    localparam logic [3:0] OP_MFLO  = 4'b1101;
`ifdef MC_ALU_DIV_EN
    localparam logic [3:0] OP_DIVU  = 4'b1010;
    localparam logic [3:0] OP_DIV   = 4'b1011;
`endif

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

`ifdef MC_ALU_DIV_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_FIX = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_FIX = 2'd3} state_t;
`endif

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;       // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]     opb_q, opb_d;       // multiplicand or divisor magnitude
    logic                 neg_q, neg_d;       // negate product / quotient in FIX
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d, result_q, result_d;
    logic                 out_valid_q, out_valid_d, is_zero_q, is_zero_d, illegal_q, illegal_d;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_prod;
`ifdef MC_ALU_DIV_EN
    logic                 is_div_q, is_div_d;
    logic                 rem_neg_q, rem_neg_d;     // remainder follows dividend sign
    logic                 div0_pend_q, div0_pend_d;
    logic                 div0_q, div0_d;
    logic [WIDTH:0]       div_part, div_diff;
    logic [WIDTH-1:0]     div_rem_nxt;
`endif

    // Magnitude of a value, treating it as two's complement only when signed.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    assign in_ready = (state_q == S_IDLE);

    // Iteration datapath: one shift-add step, and the sign-corrected product.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
        mul_prod = neg_q ? -acc_q : acc_q;
`ifdef MC_ALU_DIV_EN
        // Restoring step: shift in next dividend bit, keep difference if no borrow.
        div_part    = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff    = div_part - {1'b0, opb_q};
        div_rem_nxt = div_diff[WIDTH] ? div_part[WIDTH-1:0] : div_diff[WIDTH-1:0];
`endif
    end

    // Next-state, decode and result selection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        opb_d       = opb_q;
        neg_d       = neg_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        result_d    = '0;
        out_valid_d = 1'b0;
        is_zero_d   = 1'b0;
        illegal_d   = 1'b0;
`ifdef MC_ALU_DIV_EN
        is_div_d    = is_div_q;
        rem_neg_d   = rem_neg_q;
        div0_pend_d = div0_pend_q;
        div0_d      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    out_valid_d = 1'b1;
                    case (ALU_control)
                        OP_AND:  result_d = operand1 & operand2;
                        OP_OR:   result_d = operand1 | operand2;
                        OP_XOR:  result_d = operand1 ^ operand2;
                        OP_NOR:  result_d = ~(operand1 | operand2);
                        OP_ADD:  result_d = operand1 + operand2;
                        OP_SUB:  result_d = operand1 - operand2;
                        OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
                        OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, (operand1 < operand2)};
                        OP_MFHI: result_d = hi_q;
                        OP_MFLO: result_d = lo_q;
                        OP_MULTU, OP_MULT: begin
                            out_valid_d = 1'b0;
                            state_d     = S_MUL;
                            cnt_d       = '0;
                            acc_d       = {{WIDTH{1'b0}}, mag(operand2, ALU_control[0])};
                            opb_d       = mag(operand1, ALU_control[0]);
                            neg_d       = ALU_control[0] && (operand1[WIDTH-1] ^ operand2[WIDTH-1]);
`ifdef MC_ALU_DIV_EN
                            is_div_d    = 1'b0;
                            div0_pend_d = 1'b0;
`endif
                        end
`ifdef MC_ALU_DIV_EN
                        OP_DIVU, OP_DIV: begin
                            out_valid_d = 1'b0;
                            cnt_d       = '0;
                            is_div_d    = 1'b1;
                            if (operand2 == '0) begin
                                // FIX then passes HI = dividend, LO = all-ones unchanged.
                                state_d     = S_FIX;
                                acc_d       = {operand1, {WIDTH{1'b1}}};
                                neg_d       = 1'b0;
                                rem_neg_d   = 1'b0;
                                div0_pend_d = 1'b1;
                            end else begin
                                state_d     = S_DIV;
                                acc_d       = {{WIDTH{1'b0}}, mag(operand1, ALU_control[0])};
                                opb_d       = mag(operand2, ALU_control[0]);
                                neg_d       = ALU_control[0] && (operand1[WIDTH-1] ^ operand2[WIDTH-1]);
                                rem_neg_d   = ALU_control[0] && operand1[WIDTH-1];
                                div0_pend_d = 1'b0;
                            end
                        end
`endif
                        default: illegal_d = 1'b1;
                    endcase
                    is_zero_d = out_valid_d && (result_d == '0);
                end
            end
            S_MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_FIX;
                    cnt_d   = '0;
                end
            end
`ifdef MC_ALU_DIV_EN
            S_DIV: begin
                acc_d = {div_rem_nxt, acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_FIX;
                    cnt_d   = '0;
                end
            end
`endif
            S_FIX: begin
                hi_d = mul_prod[2*WIDTH-1:WIDTH];
                lo_d = mul_prod[WIDTH-1:0];
`ifdef MC_ALU_DIV_EN
                if (is_div_q) begin
                    lo_d   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d   = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    div0_d = div0_pend_q;
                end
`endif
                result_d    = lo_d;
                out_valid_d = 1'b1;
                is_zero_d   = (lo_d == '0);
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any operation and clears HI/LO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            opb_q       <= '0;
            neg_q       <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            is_zero_q   <= 1'b0;
            illegal_q   <= 1'b0;
`ifdef MC_ALU_DIV_EN
            is_div_q    <= 1'b0;
            rem_neg_q   <= 1'b0;
            div0_pend_q <= 1'b0;
            div0_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            opb_q       <= opb_d;
            neg_q       <= neg_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            is_zero_q   <= is_zero_d;
            illegal_q   <= illegal_d;
`ifdef MC_ALU_DIV_EN
            is_div_q    <= is_div_d;
            rem_neg_q   <= rem_neg_d;
            div0_pend_q <= div0_pend_d;
            div0_q      <= div0_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign isZero    = is_zero_q;
    assign illegal   = illegal_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
`ifdef MC_ALU_DIV_EN
    assign div0      = div0_q;
`else
    assign div0      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_alu
// Brief    : Self-checking bench for mc_alu (WIDTH = 32). A cycle-level
//            reference model built on 64-bit arithmetic predicts every output
//            each cycle; directed tests add literal expectations. Honours
//            MC_ALU_DIV_EN the same way the design does.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_alu;

    localparam int W = 32;

    logic          clk, rst_n, in_valid, in_ready, out_valid, isZero, div0, illegal;
    logic [W-1:0]  operand1, operand2, result, hi, lo;
    logic [3:0]    ALU_control;

    mc_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .operand1(operand1), .operand2(operand2), .ALU_control(ALU_control),
        .out_valid(out_valid), .result(result), .isZero(isZero), .div0(div0),
        .illegal(illegal), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int pe    = 0;               // number of rising edges so far
    always @(posedge clk) pe <= pe + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (edge %0d)", name, act, exp, pe);
        end
    endtask

    // ---------------- reference model: state after edge pe ----------------
    bit          m_busy = 0;
    int          m_done = 0;
    logic [31:0] m_hi = 0, m_lo = 0, m_res = 0, p_hi = 0, p_lo = 0;
    logic        m_ov = 0, m_zero = 0, m_div0 = 0, m_ill = 0, p_div0 = 0;
    logic [63:0] prod;
    bit          was_busy;
    int          nxt;

    typedef struct {
        logic [31:0] res, h, l;
        logic        zero, dz, ill;
        int          edg;
    } cap_t;
    cap_t cap_q[$];
    int   ov_run = 0, ov_run_max = 0;

    always @(negedge clk) begin
        // Compare DUT against the model's view after the latest edge.
        chk("in_ready", in_ready, m_busy ? 0 : 1);
        chk("out_valid", out_valid, m_ov);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        if (m_ov) begin
            chk("result", result, m_res);
            chk("isZero", isZero, m_zero);
            chk("div0", div0, m_div0);
            chk("illegal", illegal, m_ill);
        end else begin
            chk("idle_flags", {isZero, div0, illegal}, 3'b000);
        end
        if (out_valid) begin
            cap_q.push_back('{result, hi, lo, isZero, div0, illegal, pe});
            ov_run++;
            if (ov_run > ov_run_max) ov_run_max = ov_run;
        end else begin
            ov_run = 0;
        end

        // Advance the model across the next edge using the now-stable inputs.
        nxt = pe + 1;
        if (!rst_n) begin
            m_busy = 0; m_ov = 0; m_hi = 0; m_lo = 0;
            m_res = 0; m_zero = 0; m_div0 = 0; m_ill = 0;
        end else begin
            was_busy = m_busy;
            m_ov = 0; m_zero = 0; m_div0 = 0; m_ill = 0;
            if (m_busy && nxt == m_done) begin
                m_ov = 1; m_res = p_lo; m_hi = p_hi; m_lo = p_lo;
                m_div0 = p_div0; m_zero = (p_lo == 0); m_busy = 0;
            end
            if (!was_busy && in_valid) begin
                m_ov = 1;
                case (ALU_control)
                    4'b0000: m_res = operand1 & operand2;
                    4'b0001: m_res = operand1 | operand2;
                    4'b0100: m_res = operand1 ^ operand2;
                    4'b0101: m_res = ~(operand1 | operand2);
                    4'b0010: m_res = operand1 + operand2;
                    4'b0110: m_res = operand1 - operand2;
                    4'b0111: m_res = ($signed(operand1) < $signed(operand2)) ? 1 : 0;
                    4'b0011: m_res = (operand1 < operand2) ? 1 : 0;
                    4'b1100: m_res = m_hi;
                    4'b1101: m_res = m_lo;
                    4'b1000, 4'b1001: begin
                        if (ALU_control[0])
                            prod = $signed({{32{operand1[31]}}, operand1}) * $signed({{32{operand2[31]}}, operand2});
                        else
                            prod = {32'd0, operand1} * {32'd0, operand2};
                        p_hi = prod[63:32]; p_lo = prod[31:0]; p_div0 = 0;
                        m_busy = 1; m_done = nxt + W + 1; m_ov = 0;
                    end
`ifdef MC_ALU_DIV_EN
                    4'b1010, 4'b1011: begin
                        p_div0 = 0; m_busy = 1; m_ov = 0; m_done = nxt + W + 1;
                        if (operand2 == 0) begin
                            p_hi = operand1; p_lo = 32'hFFFF_FFFF; p_div0 = 1; m_done = nxt + 1;
                        end else if (!ALU_control[0]) begin
                            p_lo = operand1 / operand2; p_hi = operand1 % operand2;
                        end else if (operand1 == 32'h8000_0000 && operand2 == 32'hFFFF_FFFF) begin
                            p_lo = 32'h8000_0000; p_hi = 0;
                        end else begin
                            p_lo = $signed(operand1) / $signed(operand2);
                            p_hi = $signed(operand1) % $signed(operand2);
                        end
                    end
`endif
                    default: begin m_res = 0; m_ill = 1; end
                endcase
                if (m_ov) m_zero = (m_res == 0);
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge + #1) ----------------
    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int xe);
        int guard = 0;
        in_valid = 1; ALU_control = op; operand1 = a; operand2 = b;
        while (!in_ready && guard < 200) begin sync(); guard++; end
        if (!in_ready) chk("issue_ready_timeout", 0, 1);
        sync();
        xe = pe;
        in_valid = 0;
    endtask

    task automatic get_cap(input string name, output cap_t c);
        int n = 0;
        while (cap_q.size() == 0 && n < 200) begin @(negedge clk); #1; n++; end
        if (cap_q.size() == 0) begin
            chk({name, "_timeout"}, 0, 1);
            c = '{0, 0, 0, 0, 0, 0, 0};
        end else begin
            c = cap_q.pop_front();
        end
    endtask

    task automatic run_single(input string name, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] er, input logic ez);
        int   xe;
        cap_t c;
        issue(op, a, b, xe);
        get_cap(name, c);
        chk({name, "_res"}, c.res, er);
        chk({name, "_zero"}, c.zero, ez);
        chk({name, "_lat"}, c.edg - xe + 1, 1);
        sync();
    endtask

    typedef struct { logic [3:0] op; logic [31:0] a, b; } vec_t;
    vec_t sv_tab[9] = '{
        '{4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0}, '{4'b0001, 32'hF0F0_0000, 32'h0000_0F0F},
        '{4'b0100, 32'hAAAA_5555, 32'hFFFF_0000}, '{4'b0101, 32'h0, 32'h0},
        '{4'b0110, 32'h0, 32'h1},                 '{4'b0111, 32'h8000_0000, 32'h7FFF_FFFF},
        '{4'b0011, 32'h8000_0000, 32'h7FFF_FFFF}, '{4'b1101, 32'h0, 32'h0},
        '{4'b1110, 32'h1234, 32'h5678}};
    vec_t md_tab[7] = '{
        '{4'b1001, 32'h8000_0000, 32'h8000_0000}, '{4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{4'b1001, 32'hFFFF_FFFB, 32'hFFFF_FFF9}, '{4'b1011, 32'h8000_0000, 32'hFFFF_FFFF},
        '{4'b1011, 32'h0000_0007, 32'hFFFF_FFFE}, '{4'b1010, 32'hFFFF_FFFF, 32'h0000_0010},
        '{4'b1011, 32'hFFFF_FFF8, 32'h0}};

    initial begin
        int   xe, xe2;
        cap_t c;
        rst_n = 0; in_valid = 0; ALU_control = 0; operand1 = 0; operand2 = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        sync();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_hi_lo", {hi, lo} == 64'd0 ? 1 : 0, 1);
        chk("rst_out_valid", out_valid, 0);

        run_single("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0);
        run_single("sub_zero", 4'b0110, 32'd5, 32'd5, 32'h0, 1);

        // SLT / SLTU back to back
        ov_run_max = 0;
        issue(4'b0111, 32'hFFFF_FFFF, 32'h1, xe);
        issue(4'b0011, 32'hFFFF_FFFF, 32'h1, xe2);
        get_cap("slt", c);  chk("slt_res", c.res, 1);
        get_cap("sltu", c); chk("sltu_res", c.res, 0);
        sync(); sync();
        chk("b2b_ov_run", ov_run_max, 2);
        chk("b2b_xfer_gap", xe2 - xe, 1);

        // MULT -2 * 3, then MFHI held until accepted right after completion
        issue(4'b1001, 32'hFFFF_FFFE, 32'd3, xe);
        issue(4'b1100, 32'h0, 32'h0, xe2);
        get_cap("mult", c);
        chk("mult_lat", c.edg - xe + 1, 34);
        chk("mult_hi", c.h, 32'hFFFF_FFFF);
        chk("mult_lo", c.l, 32'hFFFF_FFFA);
        chk("mult_res", c.res, 32'hFFFF_FFFA);
        chk("model_mult_hi", m_hi, 32'hFFFF_FFFF);
        get_cap("mfhi", c);
        chk("mfhi_res", c.res, 32'hFFFF_FFFF);
        chk("mfhi_xfer", xe2 - xe, 34);
        sync();

        // DIV -7/2 and DIVU 7/0
        issue(4'b1011, 32'hFFFF_FFF9, 32'd2, xe);
        get_cap("div", c);
`ifdef MC_ALU_DIV_EN
        chk("div_lat", c.edg - xe + 1, 34);
        chk("div_lo", c.l, 32'hFFFF_FFFD);
        chk("div_hi", c.h, 32'hFFFF_FFFF);
`else
        chk("div_lat", c.edg - xe + 1, 1);
        chk("div_illegal", c.ill, 1);
        chk("div_hi_kept", c.h, 32'hFFFF_FFFF);
`endif
        sync();
        issue(4'b1010, 32'd7, 32'd0, xe);
        get_cap("divu0", c);
`ifdef MC_ALU_DIV_EN
        chk("divu0_lat", c.edg - xe + 1, 2);
        chk("divu0_flag", c.dz, 1);
        chk("divu0_lo", c.l, 32'hFFFF_FFFF);
        chk("divu0_hi", c.h, 32'd7);
`else
        chk("divu0_lat", c.edg - xe + 1, 1);
        chk("divu0_illegal", c.ill, 1);
        chk("divu0_flag", c.dz, 0);
`endif
        sync();

        // MULTU with AND held during the busy cycles
        issue(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, xe);
        issue(4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0, xe2);
        chk("and_accept_edge", xe2 - xe, 34);
        get_cap("multu", c);
        chk("multu_hi", c.h, 32'hFFFF_FFFE);
        chk("multu_lo", c.l, 32'h0000_0001);
        get_cap("and", c);
        chk("and_res", c.res, 32'h0F00_0F00);
        chk("and_lat", c.edg - xe2 + 1, 1);
        sync();

        // Table-driven single-cycle ops, issued back to back (model-checked)
        foreach (sv_tab[i]) issue(sv_tab[i].op, sv_tab[i].a, sv_tab[i].b, xe);
        repeat (3) sync();
        // Table-driven multiply/divide corner cases (model-checked)
        foreach (md_tab[i]) issue(md_tab[i].op, md_tab[i].a, md_tab[i].b, xe);
        repeat (40) sync();
        cap_q.delete();

        // Abort a long operation with reset on its 10th cycle
`ifdef MC_ALU_DIV_EN
        issue(4'b1010, 32'd1000, 32'd7, xe);
`else
        issue(4'b1000, 32'd1000, 32'd7, xe);
`endif
        repeat (9) sync();
        rst_n = 0;
        repeat (2) sync();
        rst_n = 1;
        sync();
        repeat (40) sync();
        chk("abort_no_ov", cap_q.size(), 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_ready", in_ready, 1);

        // Illegal opcode
        issue(4'b1111, 32'h1, 32'h2, xe);
        get_cap("illegal", c);
        chk("ill_flag", c.ill, 1);
        chk("ill_res", c.res, 0);
        chk("ill_zero", c.zero, 1);
        repeat (2) sync();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (edge %0d)", pe);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
